weight_az_fsm: RTL and testbench

- Perceptual weighting coefficient stage, directly downstream of the perceptual-variance block.
- Consumes one gamma value (gamma1 or gamma2 for the current subframe) and the interpolated LP coefficients a[0..M] from shared scratch memory.
- Writes ap[i] = round(a[i]·gamma^i) back to memory (G.729 Weight_Az).
- The encoder top runs it four times per frame: gamma1/gamma2 × two subframes.

---
 rtl/weight_az_fsm_pkg.sv | 27 ++
 rtl/weight_az_fsm_l_mult_round.sv | 33 +++
 rtl/weight_az_fsm.sv | 195 +++++++++++++++++++
 tb/tb_weight_az_fsm.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_az_fsm_pkg.sv
// Shared constants and types for the perceptual weighting (Weight_Az) stage.
package weight_az_fsm_pkg;

  // LP order and default memory geometry.
  localparam int unsigned LpOrder = 10;
  localparam int unsigned AddrW   = 12;
  localparam int unsigned DataW   = 32;

  // Scratch-memory bases: interpolated A coefficients per subframe and the
  // two weighted-coefficient output buffers (gamma1 / gamma2).
  localparam logic [11:0] InterpA1Base    = 12'h100;
  localparam logic [11:0] InterpA2Base    = 12'h110;
  localparam logic [11:0] WeightAzAp1Base = 12'h200;
  localparam logic [11:0] WeightAzAp2Base = 12'h210;

  // Controller states.
  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StWait0,
    StCopy,
    StWait,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/weight_az_fsm_l_mult_round.sv
// Combinational round(L_mult(x, y)) with ITU basic-op saturation.
// With WEIGHT_AZ_OVF_EN defined a saturation flag output is added.
module weight_az_fsm_l_mult_round (
  input  logic signed [15:0] x_i,
  input  logic signed [15:0] y_i,
`ifdef WEIGHT_AZ_OVF_EN
  output logic               sat_o,
`endif
  output logic        [15:0] r_o
);

  logic signed [31:0] prod;
  logic signed [31:0] lmult;
  logic signed [32:0] sum;
  logic               mult_sat;
  logic               round_sat;

  // Doubling multiply, then add 0.5 LSB of the upper half and saturate.
  always_comb begin
    prod      = 32'(x_i) * 32'(y_i);
    // Only -1 * -1 overflows the doubled product.
    mult_sat  = (x_i == 16'sh8000) && (y_i == 16'sh8000);
    lmult     = mult_sat ? 32'sh7FFF_FFFF : (prod <<< 1);
    sum       = 33'(lmult) + 33'sh0_0000_8000;
    round_sat = (sum > 33'sh0_7FFF_FFFF);
    r_o       = round_sat ? 16'h7FFF : sum[31:16];
  end

`ifdef WEIGHT_AZ_OVF_EN
  assign sat_o = mult_sat | round_sat;
`endif

endmodule

// File: rtl/weight_az_fsm.sv
// Weight_Az controller: ap[i] = round(a[i] * gamma^i), i = 0..M, read from and
// written back to shared scratch memory. Memory reads have one cycle of
// latency; all memory-side outputs are registered.
// Optional build macro WEIGHT_AZ_OVF_EN adds a sticky saturation flag (ovf).
module weight_az_fsm
  import weight_az_fsm_pkg::*;
#(
  parameter int unsigned M      = LpOrder,
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = DataW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       gamma,
  input  logic [ADDR_W-1:0] aAddr,
  input  logic [ADDR_W-1:0] apAddr,
  input  logic [DATA_W-1:0] memIn,
  output logic [ADDR_W-1:0] memReadAddr,
  output logic [ADDR_W-1:0] memWriteAddr,
  output logic [DATA_W-1:0] memOut,
  output logic              memWrite,
`ifdef WEIGHT_AZ_OVF_EN
  output logic              ovf,
`endif
  output logic              done
);

  localparam int unsigned IdxW = $clog2(M + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [ADDR_W-1:0] ap_addr_q, ap_addr_d;
  logic [15:0]       gamma_q, gamma_d;
  logic [15:0]       fac_q, fac_d;
  logic [IdxW-1:0]   i_q, i_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              done_q, done_d;

  logic [15:0]       ap_val;
  logic [15:0]       fac_val;

  // Upper half of the read word carries no information.
  logic              unused_mem_hi;
  assign unused_mem_hi = ^memIn[DATA_W-1:16];

`ifdef WEIGHT_AZ_OVF_EN
  logic ovf_q, ovf_d;
  logic ap_sat, fac_sat;
`endif

  // ap[i] = round(a[i] * fac), fac = gamma^i.
  weight_az_fsm_l_mult_round u_ap_mult (
    .x_i   (memIn[15:0]),
`ifdef WEIGHT_AZ_OVF_EN
    .sat_o (ap_sat),
`endif
    .y_i   (fac_q),
    .r_o   (ap_val)
  );

  // Next power of gamma.
  weight_az_fsm_l_mult_round u_fac_mult (
    .x_i   (fac_q),
`ifdef WEIGHT_AZ_OVF_EN
    .sat_o (fac_sat),
`endif
    .y_i   (gamma_q),
    .r_o   (fac_val)
  );

  // State and datapath registers; async reset abandons any run in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      a_addr_q  <= '0;
      ap_addr_q <= '0;
      gamma_q   <= '0;
      fac_q     <= '0;
      i_q       <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
`ifdef WEIGHT_AZ_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_addr_q  <= a_addr_d;
      ap_addr_q <= ap_addr_d;
      gamma_q   <= gamma_d;
      fac_q     <= fac_d;
      i_q       <= i_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      done_q    <= done_d;
`ifdef WEIGHT_AZ_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    a_addr_d  = a_addr_q;
    ap_addr_d = ap_addr_q;
    gamma_d   = gamma_q;
    fac_d     = fac_q;
    i_d       = i_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    done_d    = done_q;
`ifdef WEIGHT_AZ_OVF_EN
    ovf_d     = ovf_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          gamma_d   = gamma;
          fac_d     = gamma;
          a_addr_d  = aAddr;
          ap_addr_d = apAddr;
          done_d    = 1'b0;
`ifdef WEIGHT_AZ_OVF_EN
          ovf_d     = 1'b0;
`endif
          state_d   = StInit;
        end
      end
      StInit: begin
        rd_addr_d = a_addr_q;
        state_d   = StWait0;
      end
      StWait0: begin
        state_d = StCopy;
      end
      StCopy: begin
        // ap[0] = a[0] unchanged.
        we_d      = 1'b1;
        wr_addr_d = ap_addr_q;
        wdata_d   = memIn[15:0];
        i_d       = IdxW'(1);
        rd_addr_d = a_addr_q + ADDR_W'(1);
        state_d   = StWait;
      end
      StWait: begin
        state_d = StCalc;
      end
      StCalc: begin
        we_d      = 1'b1;
        wr_addr_d = ap_addr_q + ADDR_W'(i_q);
        wdata_d   = ap_val;
        fac_d     = fac_val;
`ifdef WEIGHT_AZ_OVF_EN
        ovf_d     = ovf_q | ap_sat | fac_sat;
`endif
        if (i_q == IdxW'(M)) begin
          state_d = StDone;
        end else begin
          i_d       = i_q + IdxW'(1);
          rd_addr_d = a_addr_q + ADDR_W'(i_q) + ADDR_W'(1);
          state_d   = StWait;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign memReadAddr  = rd_addr_q;
  assign memWriteAddr = wr_addr_q;
  assign memOut       = {{(DATA_W - 16){1'b0}}, wdata_q};
  assign memWrite     = we_q;
  assign done         = done_q;
`ifdef WEIGHT_AZ_OVF_EN
  assign ovf          = ovf_q;
`endif

endmodule

// File: tb/tb_weight_az_fsm.sv
// Self-checking bench for weight_az_fsm against a behavioural Weight_Az model.
module tb_weight_az_fsm;
  import weight_az_fsm_pkg::*;

  localparam int NumCoef = 11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] gamma;
  logic [11:0] aAddr;
  logic [11:0] apAddr;
  logic [31:0] memIn;
  logic [11:0] memReadAddr;
  logic [11:0] memWriteAddr;
  logic [31:0] memOut;
  logic        memWrite;
  logic        done;
`ifdef WEIGHT_AZ_OVF_EN
  logic        ovf;
`endif

  // Scratch memory with a bench-side preload port.
  logic [31:0] mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;
  logic [11:0] wlog[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] a_ref  [0:NumCoef-1];
  logic [15:0] ap_ref [0:NumCoef-1];
  bit          ovf_ref;

  always #5 clk = ~clk;

  weight_az_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .gamma        (gamma),
    .aAddr        (aAddr),
    .apAddr       (apAddr),
    .memIn        (memIn),
    .memReadAddr  (memReadAddr),
    .memWriteAddr (memWriteAddr),
    .memOut       (memOut),
    .memWrite     (memWrite),
`ifdef WEIGHT_AZ_OVF_EN
    .ovf          (ovf),
`endif
    .done         (done)
  );

  always @(posedge clk) begin
    memIn <= mem[memReadAddr];
    if (memWrite) begin
      mem[memWriteAddr] <= memOut;
      wlog.push_back(memWriteAddr);
    end
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  // ITU round(L_mult(x, y)) in plain integer arithmetic.
  function automatic int rlm(input int x, input int y, inout bit sat);
    longint p;
    longint s;
    p = longint'(x) * longint'(y) * 2;
    if (p > 64'sd2147483647) begin p = 64'sd2147483647; sat = 1'b1; end
    s = p + 64'sd32768;
    if (s > 64'sd2147483647) begin s = 64'sd2147483647; sat = 1'b1; end
    return int'(s >>> 16);
  endfunction

  // ap[i] = a[i] * gamma^i with the powers of gamma rounded step by step.
  function automatic void compute_model(input logic [15:0] g);
    int fac;
    int gs;
    bit sat;
    sat = 1'b0;
    gs  = int'($signed(g));
    fac = gs;
    ap_ref[0] = a_ref[0];
    for (int k = 1; k < NumCoef; k++) begin
      ap_ref[k] = 16'(rlm(int'($signed(a_ref[k])), fac, sat));
      fac       = rlm(fac, gs, sat);
    end
    ovf_ref = sat;
  endfunction

  task automatic poke(input logic [11:0] ad, input logic [31:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = ad;
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Upper halfword gets junk; the DUT must ignore it.
  task automatic load_a(input logic [11:0] aa);
    for (int k = 0; k < NumCoef; k++) poke(12'(aa + k), {16'($urandom), a_ref[k]});
  endtask

  task automatic randomize_a();
    for (int k = 0; k < NumCoef; k++) a_ref[k] = 16'($urandom);
  endtask

  // One run with start dropped after acceptance; lat = edges until done seen.
  task automatic do_run(input logic [15:0] g, input logic [11:0] aa, input logic [11:0] pa,
                        output int lat);
    @(negedge clk);
    gamma  = g;
    aAddr  = aa;
    apAddr = pa;
    start  = 1'b1;
    wlog.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    gamma  = '0;
    aAddr  = '0;
    apAddr = '0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
    n_checks++; if (memWrite !== 1'b0) $display("FAIL reset_we got=%b want=0", memWrite);
    else n_pass++;
    n_checks++; if (memReadAddr !== 12'h0) $display("FAIL reset_raddr got=%h want=0", memReadAddr);
    else n_pass++;
    n_checks++; if (memWriteAddr !== 12'h0) $display("FAIL reset_waddr got=%h want=0", memWriteAddr);
    else n_pass++;
    n_checks++; if (memOut !== 32'h0) $display("FAIL reset_wdata got=%h want=0", memOut);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // All a[i] = 4096, gamma = 0x7333; hand-derived first three outputs.
  task automatic test_constant();
    int lat;
    for (int k = 0; k < NumCoef; k++) a_ref[k] = 16'h1000;
    compute_model(16'h7333);
    load_a(InterpA1Base);
    do_run(16'h7333, InterpA1Base, WeightAzAp1Base, lat);
    n_checks++; if (lat !== 25) $display("FAIL const_latency got=%0d want=25", lat); else n_pass++;
    n_checks++; if (mem[WeightAzAp1Base] !== 32'h0000_1000)
      $display("FAIL const_ap0 got=%h want=00001000", mem[WeightAzAp1Base]); else n_pass++;
    n_checks++; if (mem[WeightAzAp1Base + 1] !== 32'h0000_0E66)
      $display("FAIL const_ap1 got=%h want=00000e66", mem[WeightAzAp1Base + 1]); else n_pass++;
    // fac = 0x67AE; 4096*0x67AE*2 = 0x0CF5C000, + 0x8000 rounds up to 0x0CF6.
    n_checks++; if (mem[WeightAzAp1Base + 2] !== 32'h0000_0CF6)
      $display("FAIL const_ap2 got=%h want=00000cf6", mem[WeightAzAp1Base + 2]); else n_pass++;
    for (int k = 0; k < NumCoef; k++) begin
      n_checks++;
      if (mem[12'(WeightAzAp1Base + k)] !== {16'h0, ap_ref[k]})
        $display("FAIL const_ap%0d got=%h want=%h", k, mem[12'(WeightAzAp1Base + k)], ap_ref[k]);
      else n_pass++;
    end
  endtask

  // a[1] = -1.0 with gamma just under 1.0 must not saturate.
  task automatic test_corner();
    int lat;
    randomize_a();
    a_ref[1] = 16'h8000;
    load_a(InterpA2Base);
    do_run(16'h7FFF, InterpA2Base, WeightAzAp2Base, lat);
    n_checks++; if (mem[WeightAzAp2Base + 1] !== 32'h0000_8001)
      $display("FAIL corner_ap1 got=%h want=00008001", mem[WeightAzAp2Base + 1]); else n_pass++;
`ifdef WEIGHT_AZ_OVF_EN
    n_checks++; if (ovf !== 1'b0) $display("FAIL corner_ovf got=%b want=0", ovf); else n_pass++;
    // gamma = -1.0 with a[1] = -1.0 saturates.
    do_run(16'h8000, InterpA2Base, WeightAzAp2Base, lat);
    n_checks++; if (ovf !== 1'b1) $display("FAIL corner_ovf_sat got=%b want=1", ovf); else n_pass++;
    n_checks++; if (mem[WeightAzAp2Base + 1] !== 32'h0000_7FFF)
      $display("FAIL corner_sat_ap1 got=%h want=00007fff", mem[WeightAzAp2Base + 1]); else n_pass++;
`endif
  endtask

  // gamma = 0: only ap[0] survives; exactly 11 ascending writes.
  task automatic test_gamma_zero();
    int lat;
    randomize_a();
    load_a(InterpA1Base);
    do_run(16'h0000, InterpA1Base, WeightAzAp2Base, lat);
    n_checks++; if (mem[WeightAzAp2Base] !== {16'h0, a_ref[0]})
      $display("FAIL gz_ap0 got=%h want=%h", mem[WeightAzAp2Base], a_ref[0]); else n_pass++;
    for (int k = 1; k < NumCoef; k++) begin
      n_checks++;
      if (mem[12'(WeightAzAp2Base + k)] !== 32'h0)
        $display("FAIL gz_ap%0d got=%h want=0", k, mem[12'(WeightAzAp2Base + k)]);
      else n_pass++;
    end
    n_checks++; if (wlog.size() !== NumCoef)
      $display("FAIL gz_write_count got=%0d want=%0d", wlog.size(), NumCoef); else n_pass++;
    for (int k = 0; k < wlog.size() && k < NumCoef; k++) begin
      n_checks++;
      if (wlog[k] !== 12'(WeightAzAp2Base + k))
        $display("FAIL gz_write_order idx=%0d got=%h want=%h", k, wlog[k],
                 12'(WeightAzAp2Base + k));
      else n_pass++;
    end
  endtask

  // Both buffers straddle the top of the address space.
  task automatic test_wrap();
    int lat;
    logic [15:0] g;
    randomize_a();
    g = 16'($urandom);
    compute_model(g);
    load_a(12'hFFC);
    do_run(g, 12'hFFC, 12'hFF8, lat);
    for (int k = 0; k < NumCoef; k++) begin
      n_checks++;
      if (mem[12'(12'hFF8 + k)] !== {16'h0, ap_ref[k]})
        $display("FAIL wrap_ap%0d got=%h want=%h", k, mem[12'(12'hFF8 + k)], ap_ref[k]);
      else n_pass++;
    end
  endtask

  // 60 frames x 4 calls with random coefficients and gammas.
  task automatic test_frames();
    int lat;
    logic [15:0] g;
    logic [11:0] aa;
    logic [11:0] pa;
    for (int f = 0; f < 60; f++) begin
      for (int c = 0; c < 4; c++) begin
        aa = c[1] ? InterpA2Base : InterpA1Base;
        pa = c[0] ? WeightAzAp2Base : WeightAzAp1Base;
        if (c == 0) randomize_a();
        if (c == 2) randomize_a();
        g = ((f % 13) == 5) ? 16'h8000 : 16'($urandom);
        if (c == 0 || c == 2) load_a(aa);
        compute_model(g);
        do_run(g, aa, pa, lat);
        n_checks++; if (lat !== 25) $display("FAIL frame_latency f=%0d c=%0d got=%0d want=25",
                                           f, c, lat); else n_pass++;
        n_checks++; if (wlog.size() !== NumCoef)
          $display("FAIL frame_writes f=%0d c=%0d got=%0d want=11", f, c, wlog.size());
        else n_pass++;
        for (int k = 0; k < NumCoef; k++) begin
          n_checks++;
          if (mem[12'(pa + k)] !== {16'h0, ap_ref[k]})
            $display("FAIL frame_ap f=%0d c=%0d k=%0d got=%h want=%h", f, c, k,
                     mem[12'(pa + k)], ap_ref[k]);
          else n_pass++;
        end
`ifdef WEIGHT_AZ_OVF_EN
        n_checks++; if (ovf !== ovf_ref)
          $display("FAIL frame_ovf f=%0d c=%0d got=%b want=%b", f, c, ovf, ovf_ref);
        else n_pass++;
`endif
      end
    end
  endtask

  // Reset in CALC with i = 5: ap[0..4] written, ap[5..10] untouched.
  task automatic test_midrun_reset();
    int cyc;
    int lat;
    logic [15:0] g;
    randomize_a();
    g = 16'($urandom);
    compute_model(g);
    load_a(InterpA1Base);
    for (int k = 0; k < NumCoef; k++) poke(12'(WeightAzAp1Base + k), 32'hDEAD_BEEF);
    @(negedge clk);
    gamma  = g;
    aAddr  = InterpA1Base;
    apAddr = WeightAzAp1Base;
    start  = 1'b1;
    wlog.delete();
    cyc = 0;
    while (cyc < 13) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
    end
    reset = 1'b1;
    #1;
    n_checks++; if (memWrite !== 1'b0) $display("FAIL mrst_we got=%b want=0", memWrite);
    else n_pass++;
    n_checks++; if (memReadAddr !== 12'h0) $display("FAIL mrst_raddr got=%h want=0", memReadAddr);
    else n_pass++;
    n_checks++; if (memWriteAddr !== 12'h0)
      $display("FAIL mrst_waddr got=%h want=0", memWriteAddr); else n_pass++;
    n_checks++; if (memOut !== 32'h0) $display("FAIL mrst_wdata got=%h want=0", memOut);
    else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL mrst_done got=%b want=0", done); else n_pass++;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    n_checks++; if (wlog.size() !== 5) $display("FAIL mrst_writes got=%0d want=5", wlog.size());
    else n_pass++;
    for (int k = 0; k < NumCoef; k++) begin
      n_checks++;
      if (k < 5 && mem[12'(WeightAzAp1Base + k)] !== {16'h0, ap_ref[k]})
        $display("FAIL mrst_ap%0d got=%h want=%h", k, mem[12'(WeightAzAp1Base + k)], ap_ref[k]);
      else if (k >= 5 && mem[12'(WeightAzAp1Base + k)] !== 32'hDEAD_BEEF)
        $display("FAIL mrst_ap%0d got=%h want=deadbeef", k, mem[12'(WeightAzAp1Base + k)]);
      else n_pass++;
    end
    do_run(g, InterpA1Base, WeightAzAp1Base, lat);
    n_checks++; if (lat !== 25) $display("FAIL mrst_rerun_latency got=%0d want=25", lat);
    else n_pass++;
    for (int k = 0; k < NumCoef; k++) begin
      n_checks++;
      if (mem[12'(WeightAzAp1Base + k)] !== {16'h0, ap_ref[k]})
        $display("FAIL mrst_rerun_ap%0d got=%h want=%h", k, mem[12'(WeightAzAp1Base + k)],
                 ap_ref[k]);
      else n_pass++;
    end
  endtask

  // start held high: second run follows the one-cycle done pulse; junk on
  // gamma/aAddr/apAddr mid-run must not matter.
  task automatic test_back_to_back();
    logic [15:0] g1;
    logic [15:0] g2;
    logic [15:0] exp1 [0:NumCoef-1];
    int cyc;
    int second_done;
    g1 = 16'($urandom);
    g2 = 16'($urandom);
    randomize_a();
    compute_model(g1);
    load_a(InterpA1Base);
    for (int k = 0; k < NumCoef; k++) exp1[k] = ap_ref[k];
    randomize_a();
    compute_model(g2);
    load_a(InterpA2Base);
    @(negedge clk);
    gamma  = g1;
    aAddr  = InterpA1Base;
    apAddr = WeightAzAp1Base;
    start  = 1'b1;
    wlog.delete();
    cyc = 0;
    second_done = 0;
    while (cyc < 120 && second_done == 0) begin
      @(posedge clk);
      #1;
      cyc++;
      if ((cyc >= 2 && cyc <= 23) || (cyc >= 27 && cyc <= 45)) begin
        gamma  = 16'($urandom);
        aAddr  = 12'($urandom);
        apAddr = 12'($urandom);
      end
      if (cyc == 24) begin
        gamma  = g2;
        aAddr  = InterpA2Base;
        apAddr = WeightAzAp2Base;
      end
      if (cyc == 25) begin
        n_checks++; if (done !== 1'b1) $display("FAIL b2b_first_done got=%b want=1", done);
        else n_pass++;
      end
      if (cyc == 26) begin
        n_checks++; if (done !== 1'b0) $display("FAIL b2b_restart got=%b want=0", done);
        else n_pass++;
        start = 1'b0;
      end
      if (cyc > 26 && done === 1'b1) second_done = cyc;
    end
    n_checks++; if (second_done !== 50)
      $display("FAIL b2b_second_done got=%0d want=50", second_done); else n_pass++;
    n_checks++; if (wlog.size() !== 2 * NumCoef)
      $display("FAIL b2b_writes got=%0d want=22", wlog.size()); else n_pass++;
    for (int k = 0; k < NumCoef; k++) begin
      n_checks++;
      if (mem[12'(WeightAzAp1Base + k)] !== {16'h0, exp1[k]})
        $display("FAIL b2b_run1_ap%0d got=%h want=%h", k, mem[12'(WeightAzAp1Base + k)], exp1[k]);
      else n_pass++;
      n_checks++;
      if (mem[12'(WeightAzAp2Base + k)] !== {16'h0, ap_ref[k]})
        $display("FAIL b2b_run2_ap%0d got=%h want=%h", k, mem[12'(WeightAzAp2Base + k)],
                 ap_ref[k]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_corner();
    test_gamma_zero();
    test_wrap();
    test_midrun_reset();
    test_back_to_back();
    test_frames();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
